// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one word at a time and sends it as an asynchronous serial
// frame: start bit, LSB-first data, optional even parity, then stop bits.
module fifo_uart_tx #(
    parameter int DATA_SIZE    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] fifo_data,
    output logic                 fifo_pop,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BMAX = (DATA_SIZE > STOP_BITS) ? DATA_SIZE : STOP_BITS;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_ONE   = CW'(1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_SIZE - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state_q,   state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_SIZE-1:0] shift_q,   shift_d;
    logic                 parity_q,  parity_d;
    logic                 tx_q,      tx_d;
    logic                 clk_wrap;
    logic                 last_stop;

    assign clk_wrap  = (clk_cnt_q == CLK_LAST);
    assign last_stop = (state_q == S_STOP) && clk_wrap && (bit_cnt_q == STOP_LAST);

    assign fifo_pop = rst & enable & ~fifo_empty & ((state_q == S_IDLE) | last_stop);
    assign done     = last_stop;
    assign busy     = (state_q != S_IDLE);
    assign tx       = tx_q;

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;

        if (state_q != S_IDLE) begin
            clk_cnt_d = clk_wrap ? '0 : clk_cnt_q + CLK_ONE;
        end

        case (state_q)
            S_IDLE: ;
            S_START: begin
                if (clk_wrap) state_d = S_DATA;
            end
            S_DATA: begin
                if (clk_wrap) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (clk_wrap) state_d = S_STOP;
            end
            S_STOP: begin
                if (clk_wrap) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop only happens in IDLE or the final stop cycle; it overrides both with a fresh frame.
        if (fifo_pop) begin
            shift_d   = fifo_data;
            parity_d  = ^fifo_data;
            state_d   = S_START;
            clk_cnt_d = '0;
            bit_cnt_d = '0;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three configurations (plain, even parity, two stop bits)
// fed from behavioural FIFOs and checked cycle by cycle against a frame-level model.
module tb_fifo_uart_tx;

    localparam int CPB  = 4;
    localparam int NDUT = 3;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic enable = 1'b0;

    logic [NDUT-1:0] empty, pop, tx, busy, done;
    logic [7:0]      data [NDUT];
    logic [7:0]      mem  [NDUT][64];
    logic [6:0]      wr   [NDUT] = '{default: 7'd0};
    logic [6:0]      rd   [NDUT] = '{default: 7'd0};

    int checks = 0, passes = 0, fails = 0;
    int cycle = 0;
    int npop    [NDUT] = '{default: 0};
    int ndone   [NDUT] = '{default: 0};
    int pop_at  [NDUT] = '{default: 0};
    int prev_at [NDUT] = '{default: 0};
    int done_at [NDUT] = '{default: 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_fifo
        assign empty[g] = (wr[g] == rd[g]);
        assign data[g]  = mem[g][rd[g][5:0]];
    end

    fifo_uart_tx #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty[0]), .fifo_data(data[0]),
        .fifo_pop(pop[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    fifo_uart_tx #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty[1]), .fifo_data(data[1]),
        .fifo_pop(pop[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    fifo_uart_tx #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty[2]), .fifo_data(data[2]),
        .fifo_pop(pop[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (pop[i]) rd[i] <= rd[i] + 7'd1;
        end
    end

    function automatic int pen(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int sbits(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic int flen(input int i);
        return CPB * (1 + 8 + pen(i) + sbits(i));
    endfunction

    // Expected line level k cycles after the pop (k = 1 .. flen).
    function automatic logic exp_tx(input logic [7:0] w, input int i, input int k);
        int idx;
        idx = (k - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        if (pen(i) == 1 && idx == 9) return ^w;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // Frame-level reference: tracks each DUT's frame position and predicts every output.
    initial begin
        logic       act  [NDUT];
        int         cyc  [NDUT];
        logic [7:0] word [NDUT];
        logic       et, eb, ed, ep;
        for (int i = 0; i < NDUT; i++) begin
            act[i] = 1'b0; cyc[i] = 0; word[i] = 8'h00;
        end
        forever begin
            @(negedge clk);
            cycle++;
            for (int i = 0; i < NDUT; i++) begin
                if (!rst) begin
                    act[i] = 1'b0;
                    chk($sformatf("rst_outputs%0d", i), 32'({pop[i], tx[i], busy[i], done[i]}), 32'(4'b0100));
                end else begin
                    if (act[i]) begin
                        cyc[i]++;
                        et = exp_tx(word[i], i, cyc[i]);
                        eb = 1'b1;
                        ed = (cyc[i] == flen(i));
                    end else begin
                        et = 1'b1; eb = 1'b0; ed = 1'b0;
                    end
                    chk($sformatf("tx%0d", i),   32'(tx[i]),   32'(et));
                    chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(eb));
                    chk($sformatf("done%0d", i), 32'(done[i]), 32'(ed));
                    if (done[i] === 1'b1) begin
                        ndone[i]++;
                        done_at[i] = cycle;
                    end
                    ep = enable & ~empty[i] & (~act[i] | (cyc[i] == flen(i)));
                    chk($sformatf("pop%0d", i), 32'(pop[i]), 32'(ep));
                    if (pop[i] === 1'b1) begin
                        word[i]    = data[i];
                        cyc[i]     = 0;
                        act[i]     = 1'b1;
                        npop[i]++;
                        prev_at[i] = pop_at[i];
                        pop_at[i]  = cycle;
                    end else if (act[i] && cyc[i] == flen(i)) begin
                        act[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int i, input logic [7:0] w);
        mem[i][wr[i][5:0]] = w;
        wr[i] = wr[i] + 7'd1;
    endtask

    task automatic wait_done(input int i, input int target, input int budget);
        int n;
        n = 0;
        while (ndone[i] < target && n < budget) begin
            step(1);
            n++;
        end
        chk($sformatf("done_wait%0d", i), 32'(ndone[i] >= target), 32'd1);
    endtask

    initial begin
        int nd;
        int busy_cnt;
        #1 rst = 1'b0;
        step(2);
        enable = 1'b1;
        push(0, 8'hA5);
        step(2);
        chk("pop_in_reset", 32'(pop[0]), 32'd0);
        chk("tx_in_reset",  32'(tx),     32'(3'b111));
        chk("busy_in_reset", 32'(busy),  32'd0);

        // Basic frame on the plain configuration, with an explicit busy-width count.
        rst = 1'b1;
        busy_cnt = 0;
        for (int n = 0; n < 60; n++) begin
            step(1);
            if (busy[0] === 1'b1) busy_cnt++;
        end
        chk("basic_ndone", 32'(ndone[0]), 32'd1);
        chk("basic_pop_to_done", 32'(done_at[0] - pop_at[0]), 32'd40);
        chk("basic_busy_cycles", 32'(busy_cnt), 32'd40);

        // Empty FIFOs with enable high: nothing should move.
        step(50);
        chk("empty_npop", 32'(npop[0] + npop[1] + npop[2]), 32'd1);
        chk("empty_tx", 32'(tx), 32'(3'b111));

        // Even parity: 0x07 carries parity 1, 0xA5 carries parity 0.
        push(1, 8'h07);
        push(1, 8'hA5);
        wait_done(1, 2, 200);
        chk("parity_frame_len", 32'(done_at[1] - pop_at[1]), 32'd44);
        chk("parity_pop_gap",   32'(pop_at[1] - prev_at[1]), 32'd44);

        // Two stop bits.
        push(2, 8'hFF);
        wait_done(2, 1, 100);
        chk("stop2_frame_len", 32'(done_at[2] - pop_at[2]), 32'd44);

        // Back-to-back frames.
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        wait_done(0, 4, 300);
        chk("b2b_npop", 32'(npop[0]), 32'd4);
        chk("b2b_gap", 32'(pop_at[0] - prev_at[0]), 32'd40);
        step(2);
        chk("b2b_empty", 32'(empty[0]), 32'd1);
        chk("b2b_idle", 32'(busy[0]), 32'd0);

        // Enable dropped during DATA of the first of two queued words.
        push(0, 8'h3C);
        push(0, 8'hC3);
        step(13);
        enable = 1'b0;
        wait_done(0, 5, 100);
        step(20);
        chk("gate_npop", 32'(npop[0]), 32'd5);
        chk("gate_left", 32'(wr[0] - rd[0]), 32'd1);
        chk("gate_idle", 32'({busy[0], tx[0]}), 32'(2'b01));
        enable = 1'b1;
        wait_done(0, 6, 100);

        // Reset during DATA bit 3, then a fresh word after release.
        push(0, 8'h96);
        step(1);
        step(17);
        rst = 1'b0;
        #1;
        chk("midrst_tx",   32'(tx[0]),   32'd1);
        chk("midrst_busy", 32'(busy[0]), 32'd0);
        nd = ndone[0];
        push(0, 8'h5A);
        step(3);
        rst = 1'b1;
        wait_done(0, nd + 1, 100);
        chk("midrst_npop", 32'(npop[0]), 32'd8);
        chk("midrst_empty", 32'(empty[0]), 32'd1);

        // Randomized traffic with enable toggling.
        for (int n = 0; n < 600; n++) begin
            int i;
            i = int'($urandom_range(NDUT - 1, 0));
            if ($urandom_range(3, 0) == 0 && (wr[i] - rd[i]) < 7'd50) push(i, 8'($urandom));
            if ($urandom_range(15, 0) == 0) enable = ~enable;
            step(1);
        end

        enable = 1'b1;
        for (int n = 0; n < 4000 && (empty !== 3'b111 || busy !== 3'b000); n++) step(1);
        chk("drain_empty", 32'(empty), 32'(3'b111));
        chk("drain_idle",  32'(busy),  32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
